// File: rtl/stream_merge_arbiter_pkg.sv
// Shared definitions for the stream merge arbiter.
// Contents:
//   DEF_NUM_REQ     - default number of requesters sharing the downstream stage
//   DEF_TIMEOUT_CYC - default cycles to wait for i_freeNext before a forced release
//   arb_state_e     - arbiter FSM state encoding, also exposed on the debug port
package stream_merge_arbiter_pkg;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_TIMEOUT_CYC = 255;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_FREE = 2'd2,
    ST_RELEASE   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/stream_merge_arbiter_if.sv
// Bundle of the arbiter's requester-side, downstream-side and error signals.
// Ports (arbiter view, modport master):
//   i_drive[NUM_REQ]   in   one-cycle request pulse per requester
//   o_free[NUM_REQ]    out  one-cycle completion pulse per requester
//   o_driveNext        out  one-cycle drive pulse to the shared downstream stage
//   o_grantId          out  index of the current owner, valid while o_busy
//   i_freeNext         in   one-cycle completion pulse from downstream
//   o_busy             out  high from ISSUE through RELEASE
//   i_clrErr           in   clears the sticky error flags
//   o_err*             out  sticky error flags (timeout, duplicate, spurious)
// Handshake: every transfer is a single-cycle pulse with no back-pressure.
// A requester pulses i_drive once and waits for its o_free pulse; the arbiter
// pulses o_driveNext once and waits for one i_freeNext pulse (or gives up after
// the timeout). Pulses that arrive when they are not expected are recorded in
// the sticky error flags and otherwise ignored.
interface stream_merge_arbiter_if
  import stream_merge_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) ();

  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] i_drive;
  logic [NUM_REQ-1:0] o_free;
  logic               o_driveNext;
  logic [GW-1:0]      o_grantId;
  logic               i_freeNext;
  logic               o_busy;
  logic               i_clrErr;
  logic               o_errTimeout;
  logic               o_errDup;
  logic               o_errSpurious;

  modport master (
    input  i_drive, i_freeNext, i_clrErr,
    output o_free, o_driveNext, o_grantId, o_busy,
    output o_errTimeout, o_errDup, o_errSpurious
  );

  modport slave (
    output i_drive, i_freeNext, i_clrErr,
    input  o_free, o_driveNext, o_grantId, o_busy,
    input  o_errTimeout, o_errDup, o_errSpurious
  );

endinterface

// File: rtl/stream_merge_arbiter_rr_pick.sv
// Combinational round-robin selector.
// Ports:
//   i_pend[N]  in   pending request bits
//   i_last     in   index granted most recently
//   o_winner   out  first pending index searching from i_last+1 (mod N)
//   o_any      out  at least one pending bit is set
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_pend,
  input  logic [$clog2(N)-1:0] i_last,
  output logic [$clog2(N)-1:0] o_winner,
  output logic                 o_any
);

  localparam int W = $clog2(N);

  always_comb begin
    int idx;
    o_winner = '0;
    o_any    = 1'b0;
    idx      = 0;
    // i_last itself is visited last, so the previous owner has lowest priority.
    for (int i = 1; i <= N; i++) begin
      idx = (int'(i_last) + i) % N;
      if (!o_any && i_pend[idx]) begin
        o_winner = W'(idx);
        o_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_merge_arbiter.sv
// Merges NUM_REQ pulse-driven requesters onto one shared downstream stage.
// Requests are latched in a pending vector and served one at a time in
// round-robin order: ISSUE pulses o_driveNext, WAIT_FREE waits for i_freeNext
// (at most TIMEOUT_CYC cycles), RELEASE pulses the owner's o_free.
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-low reset
//   bus          if   stream_merge_arbiter_if.master (see interface header)
//   o_dbg_state  out  current FSM state
module stream_merge_arbiter
  import stream_merge_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                   clk,
  input  logic                   rst,
  stream_merge_arbiter_if.master bus,
  output arb_state_e             o_dbg_state
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] pend_q, pend_d;
  logic [GW-1:0]      last_q, last_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               drive_next_q, drive_next_d;
  logic [NUM_REQ-1:0] free_q, free_d;
  logic               err_to_q, err_to_d;
  logic               err_dup_q, err_dup_d;
  logic               err_sp_q, err_sp_d;

  logic [GW-1:0]      pick_id;
  logic               pick_any;
  logic               timeout_evt;
  logic [NUM_REQ-1:0] grant_oh;
  logic [NUM_REQ-1:0] rel_mask;
  logic               dup_evt;
  logic               spur_evt;

  rr_pick #(.N(NUM_REQ)) u_rr_pick (
    .i_pend   (pend_q),
    .i_last   (last_q),
    .o_winner (pick_id),
    .o_any    (pick_any)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      pend_q       <= '0;
      last_q       <= GW'(NUM_REQ - 1);
      grant_q      <= '0;
      cnt_q        <= '0;
      drive_next_q <= 1'b0;
      free_q       <= '0;
      err_to_q     <= 1'b0;
      err_dup_q    <= 1'b0;
      err_sp_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      last_q       <= last_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      drive_next_q <= drive_next_d;
      free_q       <= free_d;
      err_to_q     <= err_to_d;
      err_dup_q    <= err_dup_d;
      err_sp_q     <= err_sp_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    timeout_evt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_id;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT_FREE;
      end
      ST_WAIT_FREE: begin
        cnt_d = cnt_q + CW'(1);
        // A completion arriving on the last allowed cycle beats the timeout.
        if (bus.i_freeNext) begin
          state_d = ST_RELEASE;
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          state_d     = ST_RELEASE;
          timeout_evt = 1'b1;
        end
      end
      ST_RELEASE: begin
        last_d  = grant_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: o_driveNext/o_free are decoded from the next state so they
  // leave the flops aligned with the ISSUE/RELEASE cycles.
  always_comb begin
    grant_oh     = NUM_REQ'(1) << grant_q;
    rel_mask     = (state_q == ST_RELEASE) ? grant_oh : '0;
    // A new request from the owner in its own RELEASE cycle re-arms it.
    pend_d       = (pend_q & ~rel_mask) | bus.i_drive;
    dup_evt      = |(bus.i_drive & pend_q & ~rel_mask);
    spur_evt     = bus.i_freeNext && (state_q != ST_WAIT_FREE);
    drive_next_d = (state_d == ST_ISSUE);
    free_d       = (state_d == ST_RELEASE) ? grant_oh : '0;
    err_to_d     = (err_to_q  && !bus.i_clrErr) || timeout_evt;
    err_dup_d    = (err_dup_q && !bus.i_clrErr) || dup_evt;
    err_sp_d     = (err_sp_q  && !bus.i_clrErr) || spur_evt;
  end

  assign bus.o_driveNext   = drive_next_q;
  assign bus.o_free        = free_q;
  assign bus.o_grantId     = grant_q;
  assign bus.o_busy        = (state_q != ST_IDLE);
  assign bus.o_errTimeout  = err_to_q;
  assign bus.o_errDup      = err_dup_q;
  assign bus.o_errSpurious = err_sp_q;
  assign o_dbg_state       = state_q;

endmodule

// File: doc/stream_merge_arbiter.md
STREAM_MERGE_ARBITER -- requirements
Module: stream_merge_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one downstream stage (2..8).
REQ-002 Parameter TIMEOUT_CYC, default 255, max cycles waited for i_freeNext before forced release (1..65535).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 i_drive  input  NUM_REQ  per-requester one-cycle request pulse.
REQ-006 o_free  output  NUM_REQ  per-requester one-cycle completion pulse.
REQ-007 o_driveNext  output  1  one-cycle drive pulse to shared downstream stage.
REQ-008 o_grantId  output  clog2(NUM_REQ)  index of requester currently owning downstream; valid while o_busy.
REQ-009 i_freeNext  input  1  one-cycle completion pulse from downstream.
REQ-010 o_busy  output  1  high from ISSUE through RELEASE inclusive.
REQ-011 i_clrErr  input  1  clears sticky error flags.
REQ-012 o_errTimeout, o_errDup, o_errSpurious  output  1 each  sticky error flags.

Function
REQ-013 Pending vector pend[NUM_REQ]: i_drive[k] high in cycle T sets pend[k] at T+1.
REQ-014 FSM states IDLE, ISSUE, WAIT_FREE, RELEASE; exactly one active.
REQ-015 IDLE: if any pend bit set, select winner round-robin starting at lastGrant+1 (mod NUM_REQ), latch into o_grantId, go ISSUE; else stay.
REQ-016 ISSUE: o_driveNext high exactly this cycle; timeout counter loaded to 0; go WAIT_FREE.
REQ-017 Latency: i_drive[k] pulse in cycle T with FSM idle and no other pend -> o_driveNext high in T+2.
REQ-018 WAIT_FREE: counter increments each cycle; i_freeNext high -> RELEASE; counter reaching TIMEOUT_CYC without i_freeNext -> set o_errTimeout, go RELEASE.
REQ-019 i_freeNext in the same cycle the counter hits TIMEOUT_CYC counts as normal completion; o_errTimeout not set.
REQ-020 RELEASE: o_free[o_grantId] high exactly this cycle; pend[o_grantId] cleared; lastGrant <= o_grantId; go IDLE.
REQ-021 Back-to-back: minimum 4 cycles between successive o_driveNext pulses (ISSUE, WAIT_FREE>=1, RELEASE, IDLE).
REQ-022 i_drive[k] while pend[k] already set and k not in RELEASE: request dropped (no second grant), o_errDup set.
REQ-023 i_drive[k] in the RELEASE cycle of k: set wins, pend[k] remains 1, no error.
REQ-024 i_freeNext outside WAIT_FREE: ignored, o_errSpurious set.
REQ-025 Sticky flags held until i_clrErr; an error event coinciding with i_clrErr leaves flag set.
REQ-026 o_free and o_driveNext are registered outputs; at most one o_free bit high per cycle.
REQ-027 Counter width clog2(TIMEOUT_CYC+1); never wraps (saturates by state exit).

Reset
REQ-028 rst low at a rising edge: FSM IDLE, pend=0, lastGrant=NUM_REQ-1 (first grant goes to index 0), counter=0.
REQ-029 Outputs during/after reset: o_driveNext=0, o_free=0, o_grantId=0, o_busy=0, all error flags=0.
REQ-030 Reset mid-transaction aborts it: no o_free issued for the in-flight owner; a later i_freeNext is treated as spurious.

Structure
REQ-031 Shared package holds FSM state enum and default parameter constants (NUM_REQ, TIMEOUT_CYC).
REQ-032 One sub-module rr_pick: combinational round-robin selector (pend, lastGrant -> winner index, anyValid).
REQ-033 No other hierarchy; no asynchronous logic or latches.

Verification
REQ-034 Reset release, i_drive=4'b0001 at T -> o_driveNext at T+2, o_grantId=0; i_freeNext at T+5 -> o_free=4'b0001 at T+6.
REQ-035 i_drive=4'b1111 same cycle -> grants in order 0,1,2,3, each with its own o_free, then o_busy=0.
REQ-036 TIMEOUT_CYC=8, no i_freeNext after grant -> o_errTimeout=1 and o_free pulse 8 cycles after WAIT_FREE entry; i_clrErr clears flag.
REQ-037 i_drive[2] twice while pending -> single grant to 2, o_errDup=1; i_freeNext while IDLE -> o_errSpurious=1.
REQ-038 rst low during WAIT_FREE for owner 1 -> no o_free[1], pend=0, next i_drive[3] granted with o_grantId=3.
REQ-039 Lastgrant=1, pend=4'b1011 -> next grant 3, then 0, then 1.
